// File: rtl/slt_sweep_checker.sv
// Self-test sweep engine for an external slt_mod: drives every signed operand pair and counts R1 mismatches.
// Optional build macro SLT_STOP_ON_FAIL_EN: stop at the first mismatch with err_cnt=1 and operands frozen.
module slt_sweep_checker #(
    parameter int unsigned size     = 4,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [size-1:0]   R2,
    output logic [size-1:0]   R3,
    input  logic [size-1:0]   R1,
    input  logic              c_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2*size:0]   err_cnt
);

    localparam int unsigned IW = 2 * size;
    localparam int unsigned EW = 2 * size + 1;
    localparam int unsigned CW = 4;
    localparam logic [IW-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [CW-1:0]   wait_cnt, wait_nxt;
    logic [EW-1:0]   err_nxt;
    logic            load_c;
    logic [size-1:0] expect_c;
    logic            mismatch_c;
    logic            c_out_unused;

    // Carry out of slt_mod is not part of the checked result.
    assign c_out_unused = c_out;

    // Index bits map to operands with the sign bit inverted so the sweep starts at the most negative value.
    function automatic logic [size-1:0] op_a(input logic [IW-1:0] i);
        return {~i[IW-1], i[IW-2:size]};
    endfunction

    function automatic logic [size-1:0] op_b(input logic [IW-1:0] i);
        return {~i[size-1], i[size-2:0]};
    endfunction

    // Next-state and sweep bookkeeping.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        wait_nxt   = wait_cnt;
        err_nxt    = err_cnt;
        load_c     = 1'b0;
        expect_c   = {{(size-1){1'b0}}, ($signed(R2) < $signed(R3))};
        mismatch_c = (R1 != expect_c);

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_nxt   = '0;
                    err_nxt   = '0;
                    load_c    = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                wait_nxt  = '0;
                state_nxt = (WAIT_CYC > 0) ? ST_WAIT : ST_CHECK;
            end
            ST_WAIT: begin
                if (wait_cnt == CW'(WAIT_CYC - 1)) begin
                    state_nxt = ST_CHECK;
                end else begin
                    wait_nxt = wait_cnt + CW'(1);
                end
            end
            ST_CHECK: begin
`ifdef SLT_STOP_ON_FAIL_EN
                if (mismatch_c) begin
                    err_nxt   = EW'(1);
                    state_nxt = ST_DONE;
                end else if (idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt   = idx + IW'(1);
                    load_c    = 1'b1;
                    state_nxt = ST_DRIVE;
                end
`else
                if (mismatch_c) begin
                    err_nxt = err_cnt + EW'(1);
                end
                if (idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt   = idx + IW'(1);
                    load_c    = 1'b1;
                    state_nxt = ST_DRIVE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, operands and status are all registered; status follows the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            err_cnt  <= '0;
            R2       <= '0;
            R3       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            wait_cnt <= wait_nxt;
            err_cnt  <= err_nxt;
            if (load_c) begin
                R2 <= op_a(idx_nxt);
                R3 <= op_b(idx_nxt);
            end
            busy <= (state_nxt == ST_DRIVE) || (state_nxt == ST_WAIT) || (state_nxt == ST_CHECK);
            done <= (state_nxt == ST_DONE);
            pass <= (state_nxt == ST_DONE) && (err_nxt == '0);
        end
    end

endmodule

// File: tb/tb_slt_sweep_checker.sv
// Randomized bench for slt_sweep_checker: an external slt_mod model with selectable faults drives R1,
// and an arithmetic reference predicts error count, done timing and final operands.
module tb_slt_sweep_checker;

    localparam int unsigned SIZE     = 4;
    localparam int unsigned WAIT     = 1;
    localparam int unsigned SPAN     = 1 << SIZE;
    localparam int unsigned N        = SPAN * SPAN;
    localparam int unsigned PAIR_CYC = WAIT + 2;
    localparam int          HALF     = 1 << (SIZE - 1);
    localparam int          BOUND    = 4 * N * PAIR_CYC;
`ifdef SLT_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [SIZE-1:0]   R2, R3, R1;
    logic              c_out;
    logic              busy, done, pass;
    logic [2*SIZE:0]   err_cnt;

    int                mode;
    logic [SIZE-1:0]   mask [N];
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    slt_sweep_checker #(.size(SIZE), .WAIT_CYC(WAIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .R2      (R2),
        .R3      (R3),
        .R1      (R1),
        .c_out   (c_out),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
    );

    // External slt_mod with optional faults: 1 = bit0 stuck-0, 2 = msb stuck-1, 3 = random per-pair corruption.
    always_comb begin
        R1 = ($signed(R2) < $signed(R3)) ? SIZE'(1) : SIZE'(0);
        case (mode)
            1:       R1[0] = 1'b0;
            2:       R1[SIZE-1] = 1'b1;
            3:       R1 = R1 ^ mask[{R2, R3}];
            default: ;
        endcase
        c_out = R2[0] ^ R3[0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk pairs in signed order and compare what the faulty slt_mod returns with a<b.
    task automatic predict(output int exp_edges, output int exp_err, output int last_pair);
        int first;
        exp_err = 0;
        first   = -1;
        for (int p = 0; p < int'(N); p++) begin
            int              a, b;
            logic [SIZE-1:0] good, obs;
            a    = p / int'(SPAN) - HALF;
            b    = p % int'(SPAN) - HALF;
            good = (a < b) ? SIZE'(1) : SIZE'(0);
            case (mode)
                1:       obs = good & ~SIZE'(1);
                2:       obs = good | SIZE'(HALF);
                3:       obs = good ^ mask[{SIZE'(a), SIZE'(b)}];
                default: obs = good;
            endcase
            if (obs != good) begin
                exp_err++;
                if (first < 0) first = p;
            end
        end
        if (STOP && first >= 0) begin
            exp_edges = int'(PAIR_CYC) * (first + 1);
            exp_err   = 1;
            last_pair = first;
        end else begin
            exp_edges = int'(N * PAIR_CYC);
            last_pair = int'(N) - 1;
        end
    endtask

    function automatic logic [SIZE-1:0] pair_a(input int p);
        return SIZE'(p / int'(SPAN) - HALF);
    endfunction

    function automatic logic [SIZE-1:0] pair_b(input int p);
        return SIZE'(p % int'(SPAN) - HALF);
    endfunction

    // Pulse start, then track edges until done; optionally poke start mid-sweep.
    task automatic run_sweep(input int m, input bit poke);
        int exp_edges, exp_err, last_pair, probe, k, p;
        mode = m;
        predict(exp_edges, exp_err, last_pair);
        probe = $urandom_range(1, exp_edges - 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_low_after_start", 32'(done), 32'd0);
        check("pass_low_after_start", 32'(pass), 32'd0);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            start = poke && (k == 10 || k == 50);
            if (k == probe) begin
                p = k / int'(PAIR_CYC);
                check("probe_R2", 32'(R2), 32'(pair_a(p)));
                check("probe_R3", 32'(R3), 32'(pair_b(p)));
            end
        end while (!done && k < BOUND);
        start = 1'b0;
        check("done_edge", 32'(k), 32'(exp_edges));
        check("err_cnt", 32'(err_cnt), 32'(exp_err));
        check("pass", 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
        check("busy_in_done", 32'(busy), 32'd0);
        check("final_R2", 32'(R2), 32'(pair_a(last_pair)));
        check("final_R3", 32'(R3), 32'(pair_b(last_pair)));
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        check("done_held", 32'(done), 32'd1);
        check("err_held", 32'(err_cnt), 32'(exp_err));
        check("R2_held", 32'(R2), 32'(pair_a(last_pair)));
    endtask

    initial begin
        int hits;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        hits  = 0;
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = ($urandom_range(0, 9) == 0) ? SIZE'($urandom_range(1, (1 << SIZE) - 1)) : '0;
            if (mask[i] != '0) hits++;
        end
        if (hits == 0) mask[N-1] = SIZE'(1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_R2", 32'(R2), 32'd0);
        check("rst_R3", 32'(R3), 32'd0);
        rst = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        run_sweep(0, 1'b1);
        run_sweep(1, 1'b0);
        run_sweep(0, 1'b0);
        run_sweep(2, 1'b0);
        run_sweep(3, 1'b0);

        // Reset mid-sweep while errors are accumulating, then restart.
        mode  = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err_cnt), 32'd0);
        check("midrst_R2", 32'(R2), 32'd0);
        check("midrst_R3", 32'(R3), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle", 32'(busy), 32'd0);
        run_sweep(0, 1'b0);
        run_sweep(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
